// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the MIPS-subset datapath.
// The controller is the producing end of all selects and write enables.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       PCWrite;
  logic       PCWriteCond;
  logic       BranchNe;
  logic       PCSource;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       MDRWrite;
  logic       RegWrite;
  logic       RegDst;
  logic       MemToReg;
  logic       ALUOutWrite;
  logic       ALUSrcA;
  logic [2:0] ALUSrcB;
  logic [2:0] ALUOp;
  logic       illegal;

  modport master (
    input  opcode, funct,
    output PCWrite, PCWriteCond, BranchNe, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MDRWrite, RegWrite, RegDst, MemToReg, ALUOutWrite, ALUSrcA, ALUSrcB, ALUOp, illegal
  );

  modport slave (
    output opcode, funct,
    input  PCWrite, PCWriteCond, BranchNe, PCSource, IorD, MemRead, MemWrite, IRWrite,
           MDRWrite, RegWrite, RegDst, MemToReg, ALUOutWrite, ALUSrcA, ALUSrcB, ALUOp, illegal
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-subset control FSM: fetch/decode/execute/memory/writeback sequencing
// with memory reads stretched by MEM_WAIT extra cycles.
module multicycle_ctrl #(
  parameter int unsigned MEM_WAIT = 1
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);
  localparam logic [2:0] WaitLast = 3'(MEM_WAIT);

  typedef enum logic [3:0] {
    StIdle, StFetch, StDecode, StExecR, StExecI, StExecLui, StAddr, StMemWr,
    StMemRd, StWbLoad, StAddmAddr, StAddmExec, StWbR, StWbI, StBranch, StIllegal
  } state_e;

  state_e     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       is_addm_q, is_addm_d;
  // Store vs load is captured in DECODE so ADDR never has to look at opcode.
  logic       is_store_q, is_store_d;
  logic       wait_done;

  assign wait_done = (wcnt_q == WaitLast);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      wcnt_q     <= '0;
      is_addm_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      is_addm_q  <= is_addm_d;
      is_store_q <= is_store_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    wcnt_d          = '0;
    is_addm_d       = is_addm_q;
    is_store_d      = is_store_q;
    bus.PCWrite     = 1'b0;
    bus.PCWriteCond = 1'b0;
    bus.BranchNe    = 1'b0;
    bus.PCSource    = 1'b0;
    bus.IorD        = 1'b0;
    bus.MemRead     = 1'b0;
    bus.MemWrite    = 1'b0;
    bus.IRWrite     = 1'b0;
    bus.MDRWrite    = 1'b0;
    bus.RegWrite    = 1'b0;
    bus.RegDst      = 1'b0;
    bus.MemToReg    = 1'b0;
    bus.ALUOutWrite = 1'b0;
    bus.ALUSrcA     = 1'b0;
    bus.ALUSrcB     = 3'b000;
    bus.ALUOp       = 3'b000;
    bus.illegal     = 1'b0;

    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        bus.MemRead = 1'b1;
        is_addm_d   = 1'b0;
        if (wait_done) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          bus.ALUSrcB = 3'b011;
          bus.ALUOp   = 3'b001;
          state_d     = StDecode;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StDecode: begin
        bus.ALUSrcB     = 3'b101;
        bus.ALUOp       = 3'b001;
        bus.ALUOutWrite = 1'b1;
        is_store_d      = (bus.opcode == 6'h2B);
        case (bus.opcode)
          6'h00:        state_d = StExecR;
          6'h08:        state_d = StExecI;
          6'h0F:        state_d = StExecLui;
          6'h23, 6'h2B: state_d = StAddr;
          6'h04, 6'h05: state_d = StBranch;
          6'h01:        state_d = StAddmAddr;
          default:      state_d = StIllegal;
        endcase
      end
      StExecR: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOutWrite = 1'b1;
        state_d         = StWbR;
        case (bus.funct)
          6'h20:   bus.ALUOp = 3'b001;
          6'h22:   bus.ALUOp = 3'b010;
          6'h24:   bus.ALUOp = 3'b011;
          default: begin
            bus.ALUOutWrite = 1'b0;
            state_d         = StIllegal;
          end
        endcase
      end
      StExecI: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 3'b010;
        bus.ALUOp       = 3'b001;
        bus.ALUOutWrite = 1'b1;
        state_d         = StWbI;
      end
      StExecLui: begin
        bus.ALUSrcB     = 3'b100;
        bus.ALUOutWrite = 1'b1;
        state_d         = StWbI;
      end
      StAddr: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 3'b111;
        bus.ALUOp       = 3'b001;
        bus.ALUOutWrite = 1'b1;
        state_d         = is_store_q ? StMemWr : StMemRd;
      end
      StMemWr: begin
        bus.IorD     = 1'b1;
        bus.MemWrite = 1'b1;
        state_d      = StFetch;
      end
      StMemRd: begin
        bus.IorD    = 1'b1;
        bus.MemRead = 1'b1;
        if (wait_done) begin
          bus.MDRWrite = 1'b1;
          state_d      = is_addm_q ? StAddmExec : StWbLoad;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StWbLoad: begin
        bus.RegWrite = 1'b1;
        bus.MemToReg = 1'b1;
        state_d      = StFetch;
      end
      StAddmAddr: begin
        bus.ALUOutWrite = 1'b1;
        is_addm_d       = 1'b1;
        state_d         = StMemRd;
      end
      StAddmExec: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUSrcB     = 3'b001;
        bus.ALUOp       = 3'b001;
        bus.ALUOutWrite = 1'b1;
        state_d         = StWbR;
      end
      StWbR: begin
        bus.RegWrite = 1'b1;
        bus.RegDst   = 1'b1;
        state_d      = StFetch;
      end
      StWbI: begin
        bus.RegWrite = 1'b1;
        state_d      = StFetch;
      end
      StBranch: begin
        bus.ALUSrcA     = 1'b1;
        bus.ALUOp       = 3'b010;
        bus.PCWriteCond = 1'b1;
        bus.PCSource    = 1'b1;
        bus.BranchNe    = (bus.opcode == 6'h05);
        state_d         = StFetch;
      end
      StIllegal: begin
        bus.illegal = 1'b1;
        state_d     = StFetch;
      end
    endcase
  end
endmodule
